sblk_inst_sched: RTL and testbench

- Instruction scheduler sitting in front of a row of superblocks.
- Accepts one instruction at a time from the host/controller, tagged with a row mask.
- Dispatches the instruction to each masked row's inst_data/inst_en when that row is idle, as seen on status_sblk (1 = busy).
- Tracks per-row progress so a row never receives a new instruction while its previous one is pending or running. Optional barrier mode issues to all masked rows in the same cycle.

---
 rtl/sblk_inst_sched.sv | 141 ++++++++++++++
 tb/tb_sblk_inst_sched.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sblk_inst_sched.sv
// Instruction scheduler for a row of superblocks: accepts one masked instruction
// at a time and strobes it into each target row once that row has gone idle.
module sblk_inst_sched #(
    parameter int N_ROW      = 3,
    parameter int WID_INST   = 14,
    parameter int STATUS_TMO = 8,
    parameter int WID_TMO    = $clog2(STATUS_TMO),
    parameter int WID_CNT    = 16
) (
    input  logic                      clk_l,
    input  logic                      rst_n,
    input  logic                      in_vld,
    output logic                      in_rdy,
    input  logic [WID_INST-1:0]       in_inst,
    input  logic [N_ROW-1:0]          in_row_mask,
    input  logic                      in_barrier,
    input  logic [N_ROW-1:0]          status_sblk,
    output logic [WID_INST*N_ROW-1:0] inst_data,
    output logic [N_ROW-1:0]          inst_en,
    output logic [N_ROW-1:0]          row_busy,
    output logic                      idle,
    output logic [WID_CNT-1:0]        issue_cnt,
    output logic                      err_empty_mask
);

    typedef enum logic {S_ACCEPT, S_ISSUE} state_t;
    typedef enum logic [1:0] {RS_IDLE, RS_ISSUED, RS_BUSY} row_state_t;

    state_t              state;
    row_state_t          row_state [N_ROW];
    logic [WID_TMO-1:0]  timer [N_ROW];
    logic [N_ROW-1:0]    pend;
    logic [N_ROW-1:0]    pend_next;
    logic [N_ROW-1:0]    row_idle;
    logic [N_ROW-1:0]    issue_set;
    logic [WID_INST-1:0] inst_hold;
    logic                barrier_hold;

    always_comb begin
        row_idle = '0;
        for (int r = 0; r < N_ROW; r++) begin
            row_idle[r] = (row_state[r] == RS_IDLE);
        end
    end

    // A barrier instruction waits until every target row is idle, then goes out at once.
    always_comb begin
        issue_set = '0;
        if (state == S_ISSUE) begin
            if (barrier_hold) begin
                issue_set = ((pend & ~row_idle) == '0) ? pend : '0;
            end else begin
                issue_set = pend & row_idle;
            end
        end
    end

    assign pend_next = pend & ~issue_set;
    assign in_rdy    = (state == S_ACCEPT);
    assign row_busy  = ~row_idle;
    assign idle      = in_rdy & ~|row_busy;

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_ACCEPT;
            pend           <= '0;
            inst_hold      <= '0;
            barrier_hold   <= 1'b0;
            inst_en        <= '0;
            inst_data      <= '0;
            issue_cnt      <= '0;
            err_empty_mask <= 1'b0;
        end else begin
            inst_en <= issue_set;
            for (int r = 0; r < N_ROW; r++) begin
                if (issue_set[r]) begin
                    inst_data[r*WID_INST +: WID_INST] <= inst_hold;
                end
            end
            case (state)
                S_ACCEPT: begin
                    if (in_vld) begin
                        inst_hold    <= in_inst;
                        pend         <= in_row_mask;
                        barrier_hold <= in_barrier;
                        if (in_row_mask == '0) begin
                            err_empty_mask <= 1'b1;
                        end else begin
                            issue_cnt <= issue_cnt + WID_CNT'(1);
                            state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    pend <= pend_next;
                    if (pend_next == '0) begin
                        state <= S_ACCEPT;
                    end
                end
                default: state <= S_ACCEPT;
            endcase
        end
    end

    // A row that never raises status after issue is released after STATUS_TMO cycles.
    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < N_ROW; r++) begin
                row_state[r] <= RS_IDLE;
                timer[r]     <= '0;
            end
        end else begin
            for (int r = 0; r < N_ROW; r++) begin
                case (row_state[r])
                    RS_IDLE: begin
                        if (issue_set[r]) begin
                            row_state[r] <= RS_ISSUED;
                            timer[r]     <= '0;
                        end
                    end
                    RS_ISSUED: begin
                        if (status_sblk[r]) begin
                            row_state[r] <= RS_BUSY;
                        end else if (timer[r] == WID_TMO'(STATUS_TMO - 1)) begin
                            row_state[r] <= RS_IDLE;
                        end else begin
                            timer[r] <= timer[r] + WID_TMO'(1);
                        end
                    end
                    RS_BUSY: begin
                        if (!status_sblk[r]) begin
                            row_state[r] <= RS_IDLE;
                        end
                    end
                    default: row_state[r] <= RS_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sblk_inst_sched.sv
// Self-checking bench for sblk_inst_sched: directed scenarios with literal
// expectations plus a randomized run compared every cycle to a behavioural model.
module tb_sblk_inst_sched;

    localparam int N   = 3;
    localparam int W   = 14;
    localparam int TMO = 8;
    localparam int WC  = 16;

    logic           clk_l;
    logic           rst_n;
    logic           in_vld;
    logic           in_rdy;
    logic [W-1:0]   in_inst;
    logic [N-1:0]   in_row_mask;
    logic           in_barrier;
    logic [N-1:0]   status_sblk;
    logic [W*N-1:0] inst_data;
    logic [N-1:0]   inst_en;
    logic [N-1:0]   row_busy;
    logic           idle;
    logic [WC-1:0]  issue_cnt;
    logic           err_empty_mask;

    int n_vec = 0;
    int n_err = 0;

    sblk_inst_sched #(
        .N_ROW(N), .WID_INST(W), .STATUS_TMO(TMO), .WID_CNT(WC)
    ) dut (
        .clk_l(clk_l), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy),
        .in_inst(in_inst), .in_row_mask(in_row_mask), .in_barrier(in_barrier),
        .status_sblk(status_sblk), .inst_data(inst_data), .inst_en(inst_en),
        .row_busy(row_busy), .idle(idle), .issue_cnt(issue_cnt),
        .err_empty_mask(err_empty_mask)
    );

    initial begin
        clk_l = 1'b0;
        forever #5 clk_l = ~clk_l;
    end

    // Behavioural model: a row is free again once its status has risen and fallen,
    // or once TMO clock edges have passed since issue without any status rise.
    bit             m_acc;
    bit [N-1:0]     m_pend;
    logic [W-1:0]   m_inst;
    bit             m_bar;
    bit [N-1:0]     m_busy;
    bit [N-1:0]     m_started;
    int             m_since [N];
    logic [W*N-1:0] m_data;
    logic [N-1:0]   m_en;
    logic [WC-1:0]  m_cnt;
    bit             m_err;
    bit             m_was_acc;
    logic [N-1:0]   m_iss;

    always @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            m_acc = 1'b1; m_pend = '0; m_inst = '0; m_bar = 1'b0;
            m_busy = '0; m_started = '0; m_data = '0; m_en = '0;
            m_cnt = '0; m_err = 1'b0;
            for (int r = 0; r < N; r++) m_since[r] = 0;
        end else begin
            m_was_acc = m_acc;
            m_iss = '0;
            if (!m_acc) begin
                if (m_bar) m_iss = ((m_pend & m_busy) == '0) ? m_pend : '0;
                else       m_iss = m_pend & ~m_busy;
            end
            for (int r = 0; r < N; r++) begin
                if (m_busy[r]) begin
                    m_since[r]++;
                    if (m_started[r]) begin
                        if (!status_sblk[r]) m_busy[r] = 1'b0;
                    end else if (status_sblk[r]) begin
                        m_started[r] = 1'b1;
                    end else if (m_since[r] >= TMO) begin
                        m_busy[r] = 1'b0;
                    end
                end
            end
            m_en = m_iss;
            for (int r = 0; r < N; r++) begin
                if (m_iss[r]) begin
                    m_busy[r] = 1'b1;
                    m_started[r] = 1'b0;
                    m_since[r] = 0;
                    m_data[r*W +: W] = m_inst;
                end
            end
            if (!m_was_acc) begin
                m_pend = m_pend & ~m_iss;
                if (m_pend == '0) m_acc = 1'b1;
            end else if (in_vld) begin
                m_inst = in_inst;
                m_pend = in_row_mask;
                m_bar  = in_barrier;
                if (in_row_mask == '0) m_err = 1'b1;
                else begin
                    m_cnt = m_cnt + 1'b1;
                    m_acc = 1'b0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_l) begin
        if (rst_n === 1'b1) begin
            checkOutput("mdl_in_rdy", 64'(in_rdy), 64'(m_acc));
            checkOutput("mdl_inst_en", 64'(inst_en), 64'(m_en));
            checkOutput("mdl_inst_data", 64'(inst_data), 64'(m_data));
            checkOutput("mdl_row_busy", 64'(row_busy), 64'(m_busy));
            checkOutput("mdl_idle", 64'(idle), 64'(m_acc && (m_busy == '0)));
            checkOutput("mdl_issue_cnt", 64'(issue_cnt), 64'(m_cnt));
            checkOutput("mdl_err", 64'(err_empty_mask), 64'(m_err));
        end
    end

    task automatic step();
        @(posedge clk_l);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [W-1:0] inst,
                                 input logic [N-1:0] mask, input logic bar);
        in_vld = v;
        in_inst = inst;
        in_row_mask = mask;
        in_barrier = bar;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 100 && idle !== 1'b1; i++) step();
        checkOutput("wait_idle", 64'(idle), 64'd1);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_in_rdy"}, 64'(in_rdy), 64'd1);
        checkOutput({tag, "_idle"}, 64'(idle), 64'd1);
        checkOutput({tag, "_row_busy"}, 64'(row_busy), 64'd0);
        checkOutput({tag, "_inst_en"}, 64'(inst_en), 64'd0);
        checkOutput({tag, "_inst_data"}, 64'(inst_data), 64'd0);
        checkOutput({tag, "_issue_cnt"}, 64'(issue_cnt), 64'd0);
        checkOutput({tag, "_err"}, 64'(err_empty_mask), 64'd0);
    endtask

    initial begin
        int busy_cycles;
        rst_n = 1'b0;
        status_sblk = '0;
        applyStimulus(1'b0, '0, '0, 1'b0);
        repeat (3) @(posedge clk_l);
        #1;
        checkReset("rst");
        rst_n = 1'b1;

        // Basic dispatch to rows 0 and 2
        applyStimulus(1'b1, 14'h1A5, 3'b101, 1'b0);
        step();
        applyStimulus(1'b0, '0, '0, 1'b0);
        checkOutput("t1_rdy_low", 64'(in_rdy), 64'd0);
        checkOutput("t1_en_wait", 64'(inst_en), 64'd0);
        checkOutput("t1_cnt", 64'(issue_cnt), 64'd1);
        step();
        checkOutput("t1_en", 64'(inst_en), 64'h5);
        checkOutput("t1_rdy_back", 64'(in_rdy), 64'd1);
        checkOutput("t1_data", 64'(inst_data), {22'd0, 14'h1A5, 14'd0, 14'h1A5} >> 0);
        step();
        checkOutput("t1_en_once", 64'(inst_en), 64'd0);
        waitIdle();

        // Row 1 made genuinely busy, then mask 011 waits on it
        applyStimulus(1'b1, 14'h0F0, 3'b010, 1'b0);
        step();
        applyStimulus(1'b0, '0, '0, 1'b0);
        step();
        checkOutput("t2_pre_en", 64'(inst_en), 64'h2);
        status_sblk = 3'b010;
        step();
        applyStimulus(1'b1, 14'h2B3, 3'b011, 1'b0);
        step();
        applyStimulus(1'b0, '0, '0, 1'b0);
        step();
        checkOutput("t2_row0_en", 64'(inst_en), 64'h1);
        checkOutput("t2_row0_data", 64'(inst_data[W-1:0]), 64'h2B3);
        for (int c = 2; c <= 9; c++) begin
            step();
            checkOutput("t2_hold_en", 64'(inst_en), 64'd0);
            checkOutput("t2_hold_rdy", 64'(in_rdy), 64'd0);
        end
        status_sblk = 3'b000;
        step();
        checkOutput("t2_c10_en", 64'(inst_en), 64'd0);
        step();
        checkOutput("t2_c11_en", 64'(inst_en), 64'h2);
        checkOutput("t2_c11_data", 64'(inst_data[W +: W]), 64'h2B3);
        checkOutput("t2_c11_rdy", 64'(in_rdy), 64'd1);
        waitIdle();

        // Barrier waits for row 2, then all three rows strobe together
        applyStimulus(1'b1, 14'h055, 3'b100, 1'b0);
        step();
        applyStimulus(1'b0, '0, '0, 1'b0);
        step();
        status_sblk = 3'b100;
        step();
        applyStimulus(1'b1, 14'h3C3, 3'b111, 1'b1);
        step();
        applyStimulus(1'b0, '0, '0, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            step();
            checkOutput("t3_hold_en", 64'(inst_en), 64'd0);
        end
        status_sblk = 3'b000;
        step();
        checkOutput("t3_c6_en", 64'(inst_en), 64'd0);
        step();
        checkOutput("t3_c7_en", 64'(inst_en), 64'h7);
        checkOutput("t3_c7_data", 64'(inst_data), {22'd0, 14'h3C3, 14'h3C3, 14'h3C3} >> 0);
        step();
        checkOutput("t3_c8_en", 64'(inst_en), 64'd0);
        waitIdle();

        // Zero-work instruction releases the row after the timeout
        applyStimulus(1'b1, 14'h011, 3'b001, 1'b0);
        step();
        applyStimulus(1'b0, '0, '0, 1'b0);
        step();
        checkOutput("t4_en", 64'(inst_en), 64'h1);
        busy_cycles = 0;
        while (row_busy[0] === 1'b1 && busy_cycles < 20) begin
            step();
            busy_cycles++;
        end
        checkOutput("t4_busy_cycles", 64'(busy_cycles), 64'd8);
        applyStimulus(1'b1, 14'h022, 3'b001, 1'b0);
        step();
        applyStimulus(1'b0, '0, '0, 1'b0);
        step();
        checkOutput("t4_reissue_en", 64'(inst_en), 64'h1);
        waitIdle();

        // Back-to-back to row 0 with a long-running first instruction
        applyStimulus(1'b1, 14'h0AA, 3'b001, 1'b0);
        step();
        applyStimulus(1'b0, '0, '0, 1'b0);
        step();
        checkOutput("t5_first_en", 64'(inst_en), 64'h1);
        applyStimulus(1'b1, 14'h0BB, 3'b001, 1'b0);
        step();
        applyStimulus(1'b0, '0, '0, 1'b0);
        status_sblk = 3'b001;
        step();
        for (int c = 0; c < 19; c++) begin
            step();
            checkOutput("t5_hold_en", 64'(inst_en), 64'd0);
        end
        status_sblk = 3'b000;
        step();
        checkOutput("t5_fall_en", 64'(inst_en), 64'd0);
        step();
        checkOutput("t5_second_en", 64'(inst_en), 64'h1);
        checkOutput("t5_second_data", 64'(inst_data[W-1:0]), 64'h0BB);
        checkOutput("t5_cnt", 64'(issue_cnt), 64'd9);
        applyStimulus(1'b1, 14'h3FF, 3'b000, 1'b0);
        step();
        applyStimulus(1'b0, '0, '0, 1'b0);
        checkOutput("t5_err", 64'(err_empty_mask), 64'd1);
        checkOutput("t5_cnt_same", 64'(issue_cnt), 64'd9);
        checkOutput("t5_rdy", 64'(in_rdy), 64'd1);
        step();
        checkOutput("t5_no_en", 64'(inst_en), 64'd0);
        waitIdle();

        // Asynchronous reset while an instruction to row 2 is still pending
        applyStimulus(1'b1, 14'h111, 3'b100, 1'b0);
        step();
        applyStimulus(1'b0, '0, '0, 1'b0);
        step();
        status_sblk = 3'b100;
        step();
        applyStimulus(1'b1, 14'h222, 3'b100, 1'b0);
        step();
        applyStimulus(1'b0, '0, '0, 1'b0);
        step();
        checkOutput("t6_pending", 64'(in_rdy), 64'd0);
        #3 rst_n = 1'b0;
        #1 checkReset("t6");
        status_sblk = 3'b000;
        @(posedge clk_l);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            checkOutput("t6_no_en", 64'(inst_en), 64'd0);
        end

        // Randomized traffic against the model
        for (int c = 0; c < 2000; c++) begin
            step();
            applyStimulus(1'($urandom_range(0, 1)), W'($urandom), N'($urandom),
                          ($urandom_range(0, 3) == 0));
            for (int r = 0; r < N; r++) begin
                if ($urandom_range(0, 3) == 0) status_sblk[r] = ~status_sblk[r];
            end
        end
        step();
        applyStimulus(1'b0, '0, '0, 1'b0);
        status_sblk = '0;
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
